alu_rr_scheduler: RTL
=====================

# alu_rr_scheduler

Round-robin scheduler sharing one W-bit adder/flag datapath (sum, carry, sign, zero, parity, overflow) among NREQ requesters. It arbitrates pending requests, registers the winner's operands, computes sum and flags in a dedicated cycle, and holds the tagged result until the consumer accepts it. It sits between the requesting units and the shared result bus, and is the only instance of the adder in the design.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 16, operand/result width
- IDW, $clog2(NREQ), requester-id width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request pending
- req_x  in  NREQ*W  packed X operands; requester i at [i*W +: W]
- req_y  in  NREQ*W  packed Y operands, same packing
- req_ready  out  NREQ  one-hot accept strobe; at most one bit high per cycle
- rsp_valid  out  1  result held valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of the requester that owns the result
- rsp_z  out  W  sum X+Y mod 2^W
- rsp_carry, rsp_sign, rsp_zero, rsp_parity, rsp_ovf  out  1 each  result flags
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: if any req_valid, pick winner g = first set bit searching from rr_ptr upward, wrapping mod NREQ. Assert req_ready[g] combinationally this cycle, capture req_x/req_y of g and g itself, go to EXEC. With no request, stay in IDLE.
- rr_ptr resets to 0; on each grant it becomes (g+1) mod NREQ.
- EXEC: compute {carry, z} = X+Y at W+1 bits and register the result and flags:
  - sign = z[W-1]
  - zero = (z == 0)
  - parity = XNOR-reduce(z), i.e. 1 when z has an even number of ones
  - ovf = (X[W-1] & Y[W-1] & ~z[W-1]) | (~X[W-1] & ~Y[W-1] & z[W-1])
  - Then go to RESP.
- RESP: rsp_valid = 1. Outputs stay stable until rsp_valid & rsp_ready, then go to IDLE.
- No arbitration occurs in EXEC or RESP. Requesters hold valid/operands until they see their req_ready bit.
- A requester deasserting req_valid before grant is legal; it is simply not granted.
- Reset in any state: FSM to IDLE, any in-flight operation discarded, no response issued. Reset values: rsp_valid 0, req_ready 0, busy 0, rsp_id 0, rsp_z 0, all flags 0, rr_ptr 0.
- rsp_* data outputs keep their last values after handshake until the next EXEC.

## Timing
- Grant cycle t (IDLE, req_ready[g]=1) -> EXEC at t+1 -> rsp_valid at t+2.
- Earliest next grant is the cycle after the RESP handshake. Peak throughput is 1 op per 3 cycles.
- req_ready depends combinationally on req_valid and state only, never on rsp_ready.
- rsp_ready held low stalls indefinitely in RESP with no output change.

## Configuration
- ALU_RR_SCHED_STATS_EN defined: adds output ovf_count [15:0]. It counts each RESP handshake with rsp_ovf=1, saturates at 0xFFFF, and resets to 0.
- ALU_RR_SCHED_STATS_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package alu_pkg holds:
  - ALU_W default (16)
  - flag-struct typedef alu_flags_t {carry, sign, zero, parity, ovf}
  - FSM state enum (IDLE, EXEC, RESP)
- Sub-module alu_flag_unit: purely combinational W-bit adder plus flag generation, instantiated once inside the EXEC path. The scheduler owns all registers.

## Test plan
- Requester 0 sends X=0x7FFF, Y=0x0001, rsp_ready=1 -> rsp_valid at grant+2: z=0x8000, sign 1, ovf 1, carry 0, zero 0, parity 0, id 0.
- Requester 2 sends X=0xFFFF, Y=0x0001 -> z=0x0000, carry 1, zero 1, parity 1, ovf 0, sign 0, id 2.
- All four req_valid high continuously after reset -> grant order 0,1,2,3,0. Exactly one req_ready bit per grant, grants spaced 3 cycles apart.
- Response pending with rsp_ready low for 5 cycles -> rsp_valid and data stable, no req_ready asserted. rsp_ready high -> IDLE next cycle, next grant follows.
- rst asserted during EXEC -> next cycle all outputs at reset values, no rsp_valid for that operation, and rr_ptr=0 (requester 0 wins next).
- With ALU_RR_SCHED_STATS_EN: three overflow results (0x8000+0x8000, 0x7FFF+0x7FFF, 0x4000+0x4000) plus one non-overflow -> ovf_count=3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the round-robin ALU scheduler: default datapath width,
// result-flag bundle and scheduler FSM states.
package alu_pkg;

    localparam int ALU_W = 16;

    typedef struct packed {
        logic carry;
        logic sign;
        logic zero;
        logic parity;
        logic ovf;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the requesting units, the result consumer
// and the shared ALU scheduler. master = requesters + consumer side,
// slave = scheduler side.
interface alu_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_z;
    logic              rsp_carry;
    logic              rsp_sign;
    logic              rsp_zero;
    logic              rsp_parity;
    logic              rsp_ovf;
    logic              busy;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_z,
        input  rsp_carry, rsp_sign, rsp_zero, rsp_parity, rsp_ovf, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_z,
        output rsp_carry, rsp_sign, rsp_zero, rsp_parity, rsp_ovf, busy
    );

endinterface

// File: rtl/alu_flag_unit.sv
// Purely combinational W-bit adder with carry/sign/zero/parity/overflow
// flags. Holds no state; the scheduler registers its outputs.
module alu_flag_unit
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] z,
    output alu_flags_t   flags
);

    logic [W:0] sum;

    // Add at W+1 bits so the carry falls out of the top bit, then derive flags
    always_comb begin
        sum          = {1'b0, x} + {1'b0, y};
        z            = sum[W-1:0];
        flags.carry  = sum[W];
        flags.sign   = sum[W-1];
        flags.zero   = (sum[W-1:0] == '0);
        flags.parity = ~^sum[W-1:0];
        flags.ovf    = (x[W-1] & y[W-1] & ~sum[W-1]) |
                       (~x[W-1] & ~y[W-1] & sum[W-1]);
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one adder/flag datapath among NREQ
// requesters: IDLE (arbitrate + capture) -> EXEC (compute, register)
// -> RESP (hold tagged result until accepted).
// Optional build macro ALU_RR_SCHED_STATS_EN adds a saturating 16-bit
// count of accepted results that carried the overflow flag (ovf_count).
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = ALU_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    alu_rr_scheduler_if.slave  bus
`ifdef ALU_RR_SCHED_STATS_EN
    ,
    output logic [15:0]        ovf_count
`endif
);

    state_t         state;
    logic [IDW-1:0] rr_ptr;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   cand;

    logic [W-1:0]   x_p0;
    logic [W-1:0]   y_p0;
    logic [IDW-1:0] id_p0;
    logic [W-1:0]   z_p0;
    alu_flags_t     flags_p0;

    logic [W-1:0]   z_p1;
    alu_flags_t     flags_p1;
    logic [IDW-1:0] id_p1;

    // Winner search: first pending requester at or after rr_ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    // Accept strobe only while idle; suppressed under reset so no grant is lost
    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && grant_found && !rst) begin
            bus.req_ready = NREQ'(1) << grant_idx;
        end
    end

    // Stage p0: capture the winner's operands and id on the grant edge
    always_ff @(posedge clk) begin
        if (state == IDLE && grant_found) begin
            x_p0  <= bus.req_x[grant_idx*W +: W];
            y_p0  <= bus.req_y[grant_idx*W +: W];
            id_p0 <= grant_idx;
        end
    end

    alu_flag_unit #(.W(W)) u_flag_unit (
        .x     (x_p0),
        .y     (y_p0),
        .z     (z_p0),
        .flags (flags_p0)
    );

    // Stage p1: scheduler FSM; result registers load only in EXEC and then hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            z_p1     <= '0;
            flags_p1 <= '0;
            id_p1    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        rr_ptr <= (grant_idx == IDW'(NREQ-1)) ? '0
                                                               : grant_idx + 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    z_p1     <= z_p0;
                    flags_p1 <= flags_p0;
                    id_p1    <= id_p0;
                    state    <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid  = (state == RESP);
    assign bus.busy       = (state != IDLE);
    assign bus.rsp_id     = id_p1;
    assign bus.rsp_z      = z_p1;
    assign bus.rsp_carry  = flags_p1.carry;
    assign bus.rsp_sign   = flags_p1.sign;
    assign bus.rsp_zero   = flags_p1.zero;
    assign bus.rsp_parity = flags_p1.parity;
    assign bus.rsp_ovf    = flags_p1.ovf;

`ifdef ALU_RR_SCHED_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Count accepted results flagged as overflow, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (state == RESP && bus.rsp_ready && flags_p1.ovf) begin
            ovf_count <= sat_inc(ovf_count);
        end
    end
`endif

endmodule
